dtack_wait_controller: RTL and testbench

Parametrised, clocked successor to the 68k DTACK generator. It arbitrates NUM_CH address-decoder select lines and acknowledges the 68k bus cycle on one of two paths:
- a per-channel programmed wait-state count, or
- a per-channel external acknowledge (DRAM, CAN, Flash controllers).

An optional bus-timeout watchdog raises bus error when no acknowledge arrives. It sits between the address decoder/peripheral controllers and the CPU DTACK/BERR pins.

---
 rtl/dtack_wait_controller_pkg.sv | 30 +++
 rtl/dtack_wait_controller_watchdog.sv | 33 +++
 rtl/dtack_wait_controller.sv | 122 ++++++++++++
 tb/tb_dtack_wait_controller.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/dtack_wait_controller_pkg.sv
// Shared types and helpers for the DTACK wait-state controller.
package dtack_pkg;

  typedef enum logic [2:0] {
    ST_END,
    ST_IDLE,
    ST_WAIT,
    ST_EXT,
    ST_ACK,
    ST_BERR
  } dtack_state_t;

  // Channel captured when AS_L falls with no select asserted.
  localparam int unsigned DEFAULT_CH = 0;

  localparam int unsigned WS_VEC_MAX = 256;
  localparam int unsigned WS_MAX     = 32;

  // Extract channel i's wait count from a packed, zero-extended count vector.
  function automatic logic [WS_MAX-1:0] ws_of(input logic [WS_VEC_MAX-1:0] vec,
                                              input int unsigned i,
                                              input int unsigned wsWidth = 4);
    logic [WS_VEC_MAX-1:0] shifted;
    logic [WS_MAX-1:0]     mask;
    shifted = vec >> (i * wsWidth);
    mask    = (wsWidth >= WS_MAX) ? '1 : ((WS_MAX'(1) << wsWidth) - WS_MAX'(1));
    return shifted[WS_MAX-1:0] & mask;
  endfunction

endpackage

// File: rtl/dtack_wait_controller_watchdog.sv
// Saturating bus-timeout counter; Expired_H is high once TIMEOUT_CYCLES edges
// have passed since the Start_H edge.
module dtack_timeout_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic Clk,
  input  logic Reset_L,
  input  logic Start_H,
  input  logic Clear_H,
  output logic Expired_H
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // The start edge itself counts as the first elapsed cycle.
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      count <= '0;
    end else if (Start_H) begin
      count <= CW'(1);
    end else if (Clear_H) begin
      count <= '0;
    end else if (count != '0 && count != LIMIT) begin
      count <= count + CW'(1);
    end
  end

  assign Expired_H = (count == LIMIT);

endmodule

// File: rtl/dtack_wait_controller.sv
// 68k DTACK/BERR generator: wait-state or external acknowledge per channel.
// Optional bus-timeout watchdog enabled by defining DTACK_TIMEOUT_EN.
module dtack_wait_controller
  import dtack_pkg::*;
#(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned WS_WIDTH       = 4,
  parameter logic [NUM_CH*WS_WIDTH-1:0] WAIT_STATES = '0,
  parameter logic [NUM_CH-1:0]          EXT_MASK    = '0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              Clk,
  input  logic              Reset_L,
  input  logic              AS_L,
  input  logic [NUM_CH-1:0] Select_H,
  input  logic [NUM_CH-1:0] ExtDtack_L,
  output logic              DtackOut_L,
  output logic              BErrOut_L,
  output logic              Busy_H
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [WS_VEC_MAX-1:0] WS_VEC = WS_VEC_MAX'(WAIT_STATES);

  dtack_state_t        state, nextState;
  logic [CH_W-1:0]     chSel, nextCh, pickCh;
  logic                pickValid;
  logic [WS_WIDTH-1:0] cnt, nextCnt;
  logic                wdExpired;
  logic [WS_WIDTH-1:0] wsTable [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ws
    assign wsTable[g] = WS_WIDTH'(ws_of(WS_VEC, g, WS_WIDTH));
  end

  always_comb begin
    pickCh    = CH_W'(DEFAULT_CH);
    pickValid = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (Select_H[i] && !pickValid) begin
        pickValid = 1'b1;
        pickCh    = CH_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state <= ST_END;
      chSel <= CH_W'(DEFAULT_CH);
      cnt   <= '0;
    end else begin
      state <= nextState;
      chSel <= nextCh;
      cnt   <= nextCnt;
    end
  end

  // Abort on AS_L rising beats everything; ACK beats a same-edge timeout.
  always_comb begin
    nextState = state;
    nextCh    = chSel;
    nextCnt   = cnt;
    case (state)
      ST_END: if (AS_L) nextState = ST_IDLE;
      ST_IDLE: begin
        if (!AS_L) begin
          nextCh = pickCh;
          if (!pickValid) begin
            nextState = ST_ACK;
          end else if (EXT_MASK[pickCh]) begin
            nextState = ST_EXT;
          end else if (wsTable[pickCh] == '0) begin
            nextState = ST_ACK;
          end else begin
            nextState = ST_WAIT;
            nextCnt   = wsTable[pickCh];
          end
        end
      end
      ST_WAIT: begin
        if (AS_L)                        nextState = ST_IDLE;
        else if (cnt == WS_WIDTH'(1))    nextState = ST_ACK;
        else if (wdExpired)              nextState = ST_BERR;
        else                             nextCnt   = cnt - WS_WIDTH'(1);
      end
      ST_EXT: begin
        if (AS_L)                    nextState = ST_IDLE;
        else if (!ExtDtack_L[chSel]) nextState = ST_ACK;
        else if (wdExpired)          nextState = ST_BERR;
      end
      ST_ACK, ST_BERR: if (AS_L) nextState = ST_IDLE;
      default: nextState = ST_END;
    endcase
  end

`ifdef DTACK_TIMEOUT_EN
  logic wdStart, wdClear;

  assign wdStart = (state == ST_IDLE) && !AS_L;
  assign wdClear = (state != ST_WAIT) && (state != ST_EXT);

  dtack_timeout_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .Clk      (Clk),
    .Reset_L  (Reset_L),
    .Start_H  (wdStart),
    .Clear_H  (wdClear),
    .Expired_H(wdExpired)
  );

  assign BErrOut_L = (state != ST_BERR) | AS_L;
`else
  assign wdExpired = 1'b0;
  assign BErrOut_L = 1'b1;
`endif

  assign DtackOut_L = (state != ST_ACK) | AS_L;
  assign Busy_H     = (state != ST_IDLE) && (state != ST_END);

endmodule

// File: tb/tb_dtack_wait_controller.sv
// Bench for dtack_wait_controller: directed vector table, reset sequence and
// randomized cycles checked against an edge-offset reference model.
module tb_dtack_wait_controller;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned TIMEOUT = 16;
`ifdef DTACK_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_L = 1'b1;
  logic       AS_L = 1'b1;
  logic [3:0] Select_H = '0;
  logic [3:0] ExtDtack_L = '1;
  logic       DtackOut_L, BErrOut_L, Busy_H;

  int checks = 0;
  int passes = 0;

  dtack_wait_controller #(
    .NUM_CH        (NUM_CH),
    .WS_WIDTH      (4),
    .WAIT_STATES   ({4'd0, 4'd2, 4'd3, 4'd0}),
    .EXT_MASK      (4'b1000),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset_L   (Reset_L),
    .AS_L      (AS_L),
    .Select_H  (Select_H),
    .ExtDtack_L(ExtDtack_L),
    .DtackOut_L(DtackOut_L),
    .BErrOut_L (BErrOut_L),
    .Busy_H    (Busy_H)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    string      name;
    logic [3:0] sel;
    logic [3:0] selAfter;
    int         extEdge;   // ExtDtack_L[3] driven low just after edge k+extEdge
    bit         noise;     // toggle ExtDtack_L[2:0] every cycle
    int         hold;      // edges sampling AS_L low
    int         dE;        // dtack low after edge k+dE (-1: never)
    int         bE;        // berr low after edge k+bE (-1: never)
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input int j, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s edge %0d: got %b expected %b", name, j, act, exp);
  endtask

  // Called with FSM in IDLE and AS_L high; returns at a negedge in IDLE.
  task automatic runCycle(input vec_t v);
    AS_L     = 1'b0;
    Select_H = v.sel;
    for (int j = 0; j < v.hold; j++) begin
      @(posedge Clk);
      #1;
      if (j == 0) Select_H = v.selAfter;
      if (j == v.extEdge) ExtDtack_L[3] = 1'b0;
      if (v.noise) ExtDtack_L[2:0] = 3'($urandom);
      @(negedge Clk);
      check({v.name, ".dtack"}, j, DtackOut_L, (v.dE >= 0 && j >= v.dE) ? 1'b0 : 1'b1);
      check({v.name, ".berr"},  j, BErrOut_L,  (v.bE >= 0 && j >= v.bE) ? 1'b0 : 1'b1);
      check({v.name, ".busy"},  j, Busy_H, 1'b1);
    end
    AS_L = 1'b1;
    #1;
    check({v.name, ".dtackRelease"}, v.hold, DtackOut_L, 1'b1);
    check({v.name, ".berrRelease"},  v.hold, BErrOut_L, 1'b1);
    @(posedge Clk);
    #1;
    ExtDtack_L = '1;
    Select_H   = '0;
    @(negedge Clk);
    check({v.name, ".idle"}, v.hold, Busy_H, 1'b0);
  endtask

  // Reference model: acknowledge edge offset from the channel rules.
  function automatic vec_t model(input logic [3:0] sel, input int extEdge, input int hold);
    int ws[4] = '{0, 3, 2, 0};
    int ch = -1;
    vec_t v;
    for (int i = 3; i >= 0; i--) if (sel[i]) ch = i;
    v.name = "rand"; v.sel = sel; v.selAfter = sel; v.extEdge = extEdge;
    v.noise = 1'b1; v.hold = hold; v.bE = -1;
    if (ch < 0)       v.dE = 0;
    else if (ch == 3) v.dE = (extEdge < 0) ? -1 : extEdge + 1;
    else              v.dE = ws[ch];
    if (ch == 3 && TO_EN && (v.dE < 0 || v.dE > int'(TIMEOUT))) begin
      v.dE = -1;
      v.bE = TIMEOUT;
    end
    return v;
  endfunction

  initial begin
    automatic int toBerr = TO_EN ? int'(TIMEOUT) : -1;
    tbl[0]  = '{"noSel",      4'b0000, 4'b0000, -1, 1'b0,  3,  0, -1};
    tbl[1]  = '{"ch1W3",      4'b0010, 4'b0010, -1, 1'b0,  5,  3, -1};
    tbl[2]  = '{"ch1Toggle",  4'b0010, 4'b0001, -1, 1'b0,  5,  3, -1};
    tbl[3]  = '{"ch2W2",      4'b0100, 4'b1000, -1, 1'b0,  4,  2, -1};
    tbl[4]  = '{"ch0W0",      4'b0001, 4'b0001, -1, 1'b0,  2,  0, -1};
    tbl[5]  = '{"prio0110",   4'b0110, 4'b0110, -1, 1'b0,  5,  3, -1};
    tbl[6]  = '{"ext5",       4'b1000, 4'b1000,  5, 1'b1,  8,  6, -1};
    tbl[7]  = '{"ext0",       4'b1000, 4'b1000,  0, 1'b0,  3,  1, -1};
    tbl[8]  = '{"extAtLimit", 4'b1000, 4'b1000, 15, 1'b0, 18, 16, -1};
    tbl[9]  = '{"extNone",    4'b1000, 4'b1000, -1, 1'b1, 20, -1, toBerr};
    tbl[10] = '{"prio1001",   4'b1001, 4'b1001, -1, 1'b0,  2,  0, -1};
    tbl[11] = '{"abortWait",  4'b0010, 4'b0010, -1, 1'b0,  2, -1, -1};

    // Reset with a cycle already in flight: stay in END until AS_L goes high.
    AS_L = 1'b0; Select_H = 4'b0010;
    #1 Reset_L = 1'b0;
    #11;
    check("rst.dtack", 0, DtackOut_L, 1'b1);
    check("rst.berr",  0, BErrOut_L, 1'b1);
    check("rst.busy",  0, Busy_H, 1'b0);
    @(negedge Clk) Reset_L = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      check("end.dtack", j, DtackOut_L, 1'b1);
      check("end.busy",  j, Busy_H, 1'b0);
    end
    AS_L = 1'b1; Select_H = '0;
    @(negedge Clk);
    check("end.toIdle", 0, Busy_H, 1'b0);

    foreach (tbl[i]) runCycle(tbl[i]);

    // Reset pulsed during a W=2 cycle with AS_L held low.
    AS_L = 1'b0; Select_H = 4'b0100;
    @(posedge Clk);
    #1 Reset_L = 1'b0;
    #1;
    check("midRst.dtack", 0, DtackOut_L, 1'b1);
    check("midRst.busy",  0, Busy_H, 1'b0);
    @(posedge Clk);
    @(negedge Clk) Reset_L = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge Clk);
      check("midRst.noAck", j, DtackOut_L, 1'b1);
      check("midRst.busyEnd", j, Busy_H, 1'b0);
    end
    AS_L = 1'b1; Select_H = '0;
    @(negedge Clk);
    runCycle('{"afterRst", 4'b0100, 4'b0100, -1, 1'b0, 4, 2, -1});

    for (int n = 0; n < 40; n++) begin
      automatic logic [3:0] sel = 4'($urandom_range(0, 15));
      automatic int e = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 20));
      automatic int hold = int'($urandom_range(1, 20));
      automatic vec_t v = model(sel, e, hold);
      v.selAfter = 4'($urandom);
      runCycle(v);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "time limit");
  end

endmodule
